axis_frame_source: RTL and testbench

AXI4-Stream pixel-frame transmitter that drives the S_AXIS input of the sobel_hls kernel in simulation and hardware bring-up. It emits one rows×cols frame of deterministic pixel words with TLAST on the final beat. Programmable inter-beat gaps exercise the kernel's input-blocking paths. It is the producer end of the stream that the kernel-side deadlock monitoring observes.

---
 rtl/axis_frame_source_if.sv | 20 ++
 rtl/axis_frame_source.sv | 153 +++++++++++++++
 tb/tb_axis_frame_source.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_source_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axis_frame_source_if
//  Description : AXI4-Stream bundle (tdata/tvalid/tready/tlast) shared by the
//                frame source (master) and the sink that consumes it (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface axis_frame_source_if #(
   parameter int DATA_W = 32
) ();
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_frame_source.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axis_frame_source
//  Description : AXI4-Stream pixel-frame transmitter. Emits one rows x cols
//                frame of incrementing pixel words starting at seed, TLAST on
//                the final beat, with an optional idle gap after every beat.
//                Optional back-pressure watchdog built in when the macro
//                AXIS_FRAME_SOURCE_STALL_WATCHDOG_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_frame_source #(
   parameter int DATA_W      = 32,
   parameter int DIM_W       = 10,
   parameter int GAP_W       = 4,
   parameter int STALL_LIMIT = 1024
) (
   input  wire logic              ap_clk,
   input  wire logic              ap_rst_n,
   input  wire logic              start,
   input  wire logic [DIM_W-1:0]  rows,
   input  wire logic [DIM_W-1:0]  cols,
   input  wire logic [DATA_W-1:0] seed,
   input  wire logic [GAP_W-1:0]  gap,
   output logic                   busy,
   output logic                   done,
   output logic                   stall_flag,
   axis_frame_source_if.master    m_axis
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [DIM_W-1:0]  r_rows;
   logic [DIM_W-1:0]  r_cols;
   logic [DIM_W-1:0]  r_row;
   logic [DIM_W-1:0]  r_col;
   logic [GAP_W-1:0]  r_gap;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic [DATA_W-1:0] r_data;

   logic              w_start_ok;
   logic              w_accept;
   logic              w_col_end;
   logic              w_last;

   // A zero-sized frame is accepted but produces no beats.
   assign w_start_ok = start && (rows != '0) && (cols != '0);
   assign w_accept   = (r_state == S_SEND) && m_axis.tready;
   assign w_col_end  = (r_col == (r_cols - DIM_W'(1)));
   assign w_last     = w_col_end && (r_row == (r_rows - DIM_W'(1)));

   // Outputs decode straight from registered state so they hold steady under back-pressure.
   assign m_axis.tvalid = (r_state == S_SEND);
   assign m_axis.tdata  = r_data;
   assign m_axis.tlast  = (r_state == S_SEND) && w_last;
   assign busy          = (r_state == S_SEND) || (r_state == S_GAP);
   assign done          = (r_state == S_FIN);

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = w_start_ok ? S_SEND : S_FIN;
         S_SEND: if (w_accept) begin
            if (w_last)           w_state_nxt = S_FIN;
            else if (r_gap != '0) w_state_nxt = S_GAP;
            else                  w_state_nxt = S_SEND;
         end
         S_GAP:  if (r_gap_cnt == '0) w_state_nxt = S_SEND;
         S_FIN:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Frame configuration, position counters, pixel value and gap timer.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rows    <= '0;
         r_cols    <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_gap     <= '0;
         r_gap_cnt <= '0;
         r_data    <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start_ok) begin
               r_rows <= rows;
               r_cols <= cols;
               r_gap  <= gap;
               r_row  <= '0;
               r_col  <= '0;
               r_data <= seed;
            end
            S_SEND: if (w_accept) begin
               r_data <= r_data + DATA_W'(1);
               // Gap timer counts down to zero, so it is loaded with gap-1.
               r_gap_cnt <= r_gap - GAP_W'(1);
               if (w_col_end) begin
                  r_col <= '0;
                  r_row <= r_row + DIM_W'(1);
               end else begin
                  r_col <= r_col + DIM_W'(1);
               end
            end
            S_GAP: if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            default: ;
         endcase
      end
   end

`ifdef AXIS_FRAME_SOURCE_STALL_WATCHDOG_EN
   localparam int                   c_STALL_W = $clog2(STALL_LIMIT + 1);
   localparam logic [c_STALL_W-1:0] c_LIMIT   = c_STALL_W'(STALL_LIMIT);

   logic [c_STALL_W-1:0] r_stall_cnt;
   logic                 r_stall_flag;

   // Count consecutive back-pressured cycles; flag is sticky once the limit is hit.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_stall_cnt  <= '0;
         r_stall_flag <= 1'b0;
      end else if ((r_state != S_SEND) || w_accept) begin
         r_stall_cnt <= '0;
      end else if (r_stall_cnt != c_LIMIT) begin
         r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
         if (r_stall_cnt == (c_LIMIT - c_STALL_W'(1))) r_stall_flag <= 1'b1;
      end
   end

   assign stall_flag = r_stall_flag;
`else
   // Watchdog not built in: flag is permanently low whatever the limit is.
   assign stall_flag = 1'b0 & (STALL_LIMIT != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_source.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axis_frame_source
//  Description : Directed self-checking bench for axis_frame_source.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axis_frame_source;

`ifdef AXIS_FRAME_SOURCE_STALL_WATCHDOG_EN
   localparam logic WD_EN = 1'b1;
`else
   localparam logic WD_EN = 1'b0;
`endif

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        start;
   logic [9:0]  rows;
   logic [9:0]  cols;
   logic [31:0] seed;
   logic [3:0]  gap;
   logic        busy;
   logic        done;
   logic        stall_flag;

   int checks   = 0;
   int failures = 0;

   axis_frame_source_if #(.DATA_W(32)) m_axis ();

   axis_frame_source #(
      .DATA_W(32), .DIM_W(10), .GAP_W(4), .STALL_LIMIT(8)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
      .rows(rows), .cols(cols), .seed(seed), .gap(gap),
      .busy(busy), .done(done), .stall_flag(stall_flag),
      .m_axis(m_axis)
   );

   always #5 ap_clk = ~ap_clk;

   // Capture results of the most recent frame
   logic [31:0] cap_d[$];
   logic        cap_l[$];
   int          cap_c[$];
   logic        vpat[64];
   int          done_cyc;
   int          stab_err;
   int          busy_err;

   task automatic pulse_start(input logic [9:0] r, input logic [9:0] c,
                              input logic [31:0] s, input logic [3:0] g);
      @(negedge ap_clk);
      start = 1'b1; rows = r; cols = c; seed = s; gap = g;
   endtask

   // mode 0: tready always 1; mode 1: tready 1,0,1,0...
   task automatic capture(input int mode, input int budget);
      logic v, l, dn, b, rdy, pv, prdy, pl;
      logic [31:0] d, pd;
      cap_d.delete(); cap_l.delete(); cap_c.delete();
      for (int i = 0; i < 64; i++) vpat[i] = 1'b0;
      done_cyc = -1; stab_err = 0; busy_err = 0;
      pv = 1'b0; prdy = 1'b1; pd = '0; pl = 1'b0;
      for (int c = 0; c < budget; c++) begin
         rdy = (mode == 0) ? 1'b1 : ((c % 2) == 0);
         @(negedge ap_clk);
         start = 1'b0;
         m_axis.tready = rdy;
         v = m_axis.tvalid; d = m_axis.tdata; l = m_axis.tlast;
         dn = done; b = busy;
         if (c < 64) vpat[c] = v;
         if (pv && !prdy && (!v || d !== pd || l !== pl)) stab_err++;
         if (v && !b) busy_err++;
         if (dn && b) busy_err++;
         if (v && rdy) begin
            cap_d.push_back(d); cap_l.push_back(l); cap_c.push_back(c);
         end
         pv = v; prdy = rdy; pd = d; pl = l;
         if (dn) begin
            done_cyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0; start = 1'b0; rows = '0; cols = '0; seed = '0; gap = '0;
      m_axis.tready = 1'b0;
      #3;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || stall_flag !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl busy=%b done=%b stall=%b required 0 0 0", busy, done, stall_flag);
      end
      checks++;
      if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0 || m_axis.tdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_axis tvalid=%b tlast=%b tdata=%h required 0 0 0",
                  m_axis.tvalid, m_axis.tlast, m_axis.tdata);
      end
      repeat (3) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
   endtask

   task automatic test_basic();
      pulse_start(10'd2, 10'd3, 32'h10, 4'd0);
      capture(0, 20);
      checks++;
      if (cap_d.size() != 6) begin
         failures++;
         $display("FAIL basic_count got %0d required 6", cap_d.size());
      end
      for (int i = 0; i < 6; i++) begin
         if (i < cap_d.size()) begin
            checks++;
            if (cap_d[i] !== 32'h10 + i || cap_l[i] !== (i == 5) || cap_c[i] != i) begin
               failures++;
               $display("FAIL basic_beat %0d got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                        i, cap_d[i], cap_l[i], cap_c[i], 32'h10 + i, (i == 5), i);
            end
         end
      end
      checks++;
      if (done_cyc != 6 || busy_err != 0) begin
         failures++;
         $display("FAIL basic_done got done_cyc=%0d busy_err=%0d required 6 0", done_cyc, busy_err);
      end
   endtask

   task automatic test_toggle();
      pulse_start(10'd2, 10'd3, 32'h10, 4'd0);
      capture(1, 30);
      checks++;
      if (cap_d.size() != 6 || stab_err != 0) begin
         failures++;
         $display("FAIL toggle_count got beats=%0d stab_err=%0d required 6 0", cap_d.size(), stab_err);
      end
      for (int i = 0; i < 6; i++) begin
         if (i < cap_d.size()) begin
            checks++;
            if (cap_d[i] !== 32'h10 + i || cap_l[i] !== (i == 5)) begin
               failures++;
               $display("FAIL toggle_beat %0d got data=%h last=%b required data=%h last=%b",
                        i, cap_d[i], cap_l[i], 32'h10 + i, (i == 5));
            end
         end
      end
      checks++;
      if (done_cyc != 11) begin
         failures++;
         $display("FAIL toggle_done got %0d required 11", done_cyc);
      end
   endtask

   task automatic test_gap();
      logic [9:0] exp_v;
      exp_v = 10'b1001001001;
      pulse_start(10'd1, 10'd4, 32'hA0, 4'd2);
      capture(0, 30);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (vpat[i] !== exp_v[i]) begin
            failures++;
            $display("FAIL gap_tvalid cyc %0d got %b required %b", i, vpat[i], exp_v[i]);
         end
      end
      checks++;
      if (cap_d.size() != 4 || done_cyc != 10) begin
         failures++;
         $display("FAIL gap_count got beats=%0d done_cyc=%0d required 4 10", cap_d.size(), done_cyc);
      end
      if (cap_l.size() == 4) begin
         checks++;
         if (cap_l[0] !== 1'b0 || cap_l[1] !== 1'b0 || cap_l[2] !== 1'b0 || cap_l[3] !== 1'b1) begin
            failures++;
            $display("FAIL gap_tlast got %b%b%b%b required 0001", cap_l[0], cap_l[1], cap_l[2], cap_l[3]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_d[3];
      exp_d[0] = 32'hFFFF_FFFE; exp_d[1] = 32'hFFFF_FFFF; exp_d[2] = 32'h0000_0000;
      pulse_start(10'd1, 10'd3, 32'hFFFF_FFFE, 4'd0);
      capture(0, 20);
      checks++;
      if (cap_d.size() != 3) begin
         failures++;
         $display("FAIL wrap_count got %0d required 3", cap_d.size());
      end
      for (int i = 0; i < 3; i++) begin
         if (i < cap_d.size()) begin
            checks++;
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== (i == 2)) begin
               failures++;
               $display("FAIL wrap_beat %0d got data=%h last=%b required data=%h last=%b",
                        i, cap_d[i], cap_l[i], exp_d[i], (i == 2));
            end
         end
      end
   endtask

   task automatic test_zero();
      pulse_start(10'd0, 10'd5, 32'h33, 4'd0);
      capture(0, 10);
      checks++;
      if (cap_d.size() != 0 || done_cyc != 0 || vpat[0] !== 1'b0 || busy_err != 0) begin
         failures++;
         $display("FAIL zero_frame got beats=%0d done_cyc=%0d tvalid0=%b busy_err=%0d required 0 0 0 0",
                  cap_d.size(), done_cyc, vpat[0], busy_err);
      end
   endtask

   task automatic test_ignore_start();
      int stray;
      pulse_start(10'd1, 10'd4, 32'h40, 4'd0);
      @(negedge ap_clk);
      start = 1'b0; m_axis.tready = 1'b0;
      checks++;
      if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 32'h40) begin
         failures++;
         $display("FAIL ignore_first got tvalid=%b tdata=%h required 1 00000040", m_axis.tvalid, m_axis.tdata);
      end
      @(negedge ap_clk);
      start = 1'b1; rows = 10'd3; cols = 10'd3; seed = 32'h99; gap = 4'd5;
      m_axis.tready = 1'b0;
      capture(0, 20);
      checks++;
      if (cap_d.size() != 4 || done_cyc != 4) begin
         failures++;
         $display("FAIL ignore_count got beats=%0d done_cyc=%0d required 4 4", cap_d.size(), done_cyc);
      end
      for (int i = 0; i < 4; i++) begin
         if (i < cap_d.size()) begin
            checks++;
            if (cap_d[i] !== 32'h40 + i || cap_l[i] !== (i == 3)) begin
               failures++;
               $display("FAIL ignore_beat %0d got data=%h last=%b required data=%h last=%b",
                        i, cap_d[i], cap_l[i], 32'h40 + i, (i == 3));
            end
         end
      end
      stray = 0;
      repeat (3) begin
         @(negedge ap_clk);
         if (m_axis.tvalid !== 1'b0 || busy !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL ignore_after got %0d active cycles required 0", stray);
      end
   endtask

   task automatic test_mid_reset();
      pulse_start(10'd2, 10'd3, 32'h10, 4'd0);
      @(negedge ap_clk);
      start = 1'b0; m_axis.tready = 1'b1;
      @(negedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      checks++;
      if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0 || m_axis.tdata !== 32'h0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midreset_out got tvalid=%b tlast=%b tdata=%h busy=%b required 0 0 0 0",
                  m_axis.tvalid, m_axis.tlast, m_axis.tdata, busy);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      pulse_start(10'd1, 10'd2, 32'h70, 4'd0);
      capture(0, 10);
      checks++;
      if (cap_d.size() != 2) begin
         failures++;
         $display("FAIL midreset_count got %0d required 2", cap_d.size());
      end else begin
         checks++;
         if (cap_d[0] !== 32'h70 || cap_d[1] !== 32'h71 || cap_l[0] !== 1'b0 || cap_l[1] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_frame got %h/%b %h/%b required 00000070/0 00000071/1",
                     cap_d[0], cap_l[0], cap_d[1], cap_l[1]);
         end
      end
   endtask

   task automatic test_stall();
      pulse_start(10'd1, 10'd2, 32'h5, 4'd0);
      for (int c = 0; c < 9; c++) begin
         @(negedge ap_clk);
         start = 1'b0; m_axis.tready = 1'b0;
         if (c == 7) begin
            checks++;
            if (stall_flag !== 1'b0 || m_axis.tdata !== 32'h5) begin
               failures++;
               $display("FAIL stall_early got flag=%b tdata=%h required 0 00000005", stall_flag, m_axis.tdata);
            end
         end
         if (c == 8) begin
            checks++;
            if (stall_flag !== WD_EN) begin
               failures++;
               $display("FAIL stall_set got %b required %b", stall_flag, WD_EN);
            end
         end
      end
      capture(0, 10);
      checks++;
      if (cap_d.size() != 2 || stall_flag !== WD_EN) begin
         failures++;
         $display("FAIL stall_sticky got beats=%0d flag=%b required 2 %b", cap_d.size(), stall_flag, WD_EN);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_gap();
      test_wrap();
      test_zero();
      test_ignore_start();
      test_mid_reset();
      test_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
